// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the 00..99 seconds stopwatch.
// Also used by the countdown timer that shares the HEX7/HEX6 pair.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } count_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam count_t COUNT_ZERO = '{tens: 4'd0, ones: 4'd0};
    localparam count_t COUNT_MAX  = '{tens: 4'd9, ones: 4'd9};

    // Two-digit BCD increment; 99 rolls over to 00.
    function automatic count_t count_next(input count_t c);
        count_t n;
        n = c;
        if (c.ones == 4'd9) begin
            n.ones = 4'd0;
            if (c.tens == 4'd9) begin
                n.tens = 4'd0;
            end else begin
                n.tens = c.tens + 4'd1;
            end
        end else begin
            n.ones = c.ones + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-low seven-segment pattern, bit0=a .. bit6=g.
// Non-BCD inputs blank the digit.
module seven_seg_decoder
    import stopwatch_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Two-digit seconds stopwatch with start/stop, lap and clear buttons.
// Lap freezes the display while the live count keeps running.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [6:0] HEX7,
    output logic [6:0] HEX6,
    output logic       running,
    output logic       wrap
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

    state_t        state;
    state_t        next_state;
    logic          ss_prev;
    logic          lap_prev;
    logic          clr_prev;
    logic          ss_rise;
    logic          lap_rise;
    logic          clr_rise;
    logic [PW-1:0] presc;
    count_t        count;
    count_t        lap_reg;
    count_t        disp;
    logic          counting;
    logic          tick;
    logic          take_lap;
    logic          zero_all;
    logic [6:0]    seg_tens;
    logic [6:0]    seg_ones;

    assign ss_rise  = start_stop & ~ss_prev;
    assign lap_rise = lap & ~lap_prev;
    assign clr_rise = clear & ~clr_prev;

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PMAX);
    assign zero_all = (next_state == IDLE);
    assign disp     = (state == LAP) ? lap_reg : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_prev  <= 1'b0;
            lap_prev <= 1'b0;
            clr_prev <= 1'b0;
        end else begin
            ss_prev  <= start_stop;
            lap_prev <= lap;
            clr_prev <= clear;
        end
    end

    // start_stop outranks lap, which outranks clear.
    always_comb begin
        next_state = state;
        take_lap   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_rise) next_state = RUN;
            end
            RUN: begin
                if (ss_rise) begin
                    next_state = PAUSE;
                end else if (lap_rise) begin
                    next_state = LAP;
                    take_lap   = 1'b1;
                end
            end
            LAP: begin
                if (ss_rise) begin
                    next_state = PAUSE;
                end else if (lap_rise) begin
                    next_state = RUN;
                end
            end
            PAUSE: begin
                if (ss_rise) begin
                    next_state = RUN;
                end else if (clr_rise) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == RUN) || (next_state == LAP);
        end
    end

    // Prescaler holds through PAUSE so a resume finishes the partial second.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            count <= COUNT_ZERO;
            wrap  <= 1'b0;
        end else begin
            wrap <= tick && (count == COUNT_MAX);
            if (zero_all) begin
                presc <= '0;
                count <= COUNT_ZERO;
            end else if (tick) begin
                presc <= '0;
                count <= count_next(count);
            end else if (counting) begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_reg <= COUNT_ZERO;
        end else if (take_lap) begin
            lap_reg <= count;
        end
    end

    seven_seg_decoder u_tens (
        .digit (disp.tens),
        .seg   (seg_tens)
    );

    seven_seg_decoder u_ones (
        .digit (disp.ones),
        .seg   (seg_ones)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            HEX7 <= SEG_ZERO;
            HEX6 <= SEG_ZERO;
        end else begin
            HEX7 <= seg_tens;
            HEX6 <= seg_ones;
        end
    end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: directed scenarios plus random button traffic
// checked every cycle against a seconds/phase reference model.
module tb_stopwatch_timer;

    localparam int T = 20;
    localparam int M_IDLE = 0;
    localparam int M_RUN = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [6:0] HEX7;
    logic [6:0] HEX6;
    logic       running;
    logic       wrap;

    always #5 clk = ~clk;

    stopwatch_timer #(.TICKS_PER_SEC(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .HEX7       (HEX7),
        .HEX6       (HEX6),
        .running    (running),
        .wrap       (wrap)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] segtab [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    int   m_mode;
    int   m_secs;
    int   m_phase;
    int   m_lap;
    bit   m_pss;
    bit   m_plp;
    bit   m_pcl;
    logic [6:0] e_h7;
    logic [6:0] e_h6;
    logic e_run;
    logic e_wrap;

    task automatic chk(input string tag, input logic [6:0] obs,
                       input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit ss, input bit lp, input bit cl);
        int  disp;
        int  old;
        bit  rs;
        bit  rl;
        bit  rc;
        disp = (m_mode == M_LAP) ? m_lap : m_secs;
        if (r) begin
            m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_lap = 0;
            m_pss = 0; m_plp = 0; m_pcl = 0;
            e_h7 = segtab[0]; e_h6 = segtab[0];
            e_run = 0; e_wrap = 0;
            return;
        end
        e_h7 = segtab[disp / 10];
        e_h6 = segtab[disp % 10];
        rs = ss && !m_pss;
        rl = lp && !m_plp;
        rc = cl && !m_pcl;
        e_wrap = 0;
        old = m_secs;
        if (m_mode == M_RUN || m_mode == M_LAP) begin
            m_phase++;
            if (m_phase == T) begin
                m_phase = 0;
                m_secs = (m_secs + 1) % 100;
                e_wrap = (m_secs == 0);
            end
        end
        case (m_mode)
            M_IDLE:  if (rs) m_mode = M_RUN;
            M_RUN:   if (rs) m_mode = M_PAUSE;
                     else if (rl) begin m_mode = M_LAP; m_lap = old; end
            M_LAP:   if (rs) m_mode = M_PAUSE;
                     else if (rl) m_mode = M_RUN;
            default: if (rs) m_mode = M_RUN;
                     else if (rc) m_mode = M_IDLE;
        endcase
        if (m_mode == M_IDLE) begin
            m_secs = 0;
            m_phase = 0;
        end
        e_run = (m_mode == M_RUN || m_mode == M_LAP);
        m_pss = ss; m_plp = lp; m_pcl = cl;
    endtask

    task automatic step(input bit r, input bit ss, input bit lp, input bit cl);
        rst = r; start_stop = ss; lap = lp; clear = cl;
        @(posedge clk);
        model(r, ss, lp, cl);
        #1;
        chk("hex7", HEX7, e_h7);
        chk("hex6", HEX6, e_h6);
        chk("running", {6'b0, running}, {6'b0, e_run});
        chk("wrap", {6'b0, wrap}, {6'b0, e_wrap});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        int k;
        int nwrap;
        int wat;
        rst = 1; start_stop = 0; lap = 0; clear = 0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_h7", HEX7, 7'b1000000);
        chk("rst_h6", HEX6, 7'b1000000);
        chk("rst_run", {6'b0, running}, 7'd0);
        chk("rst_wrap", {6'b0, wrap}, 7'd0);
        idle(3);

        step(0, 1, 0, 0);
        chk("start_run", {6'b0, running}, 7'd1);
        idle(201);
        chk("basic_h7", HEX7, 7'b1111001);
        chk("basic_h6", HEX6, 7'b1000000);

        idle(9);
        step(0, 1, 0, 0);
        chk("pause_run", {6'b0, running}, 7'd0);
        idle(100);
        chk("pause_h7", HEX7, segtab[1]);
        chk("pause_h6", HEX6, segtab[0]);
        step(0, 1, 0, 0);
        k = 41;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0);
            if (HEX6 === segtab[1]) begin
                k = i;
                break;
            end
        end
        chk_int("resume_lat", k, 10);

        step(0, 0, 0, 1);
        chk("clr_run_ignored", {6'b0, running}, 7'd1);
        idle(2);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        idle(2);
        chk("clr_h7", HEX7, segtab[0]);
        chk("clr_h6", HEX6, segtab[0]);
        chk("clr_run", {6'b0, running}, 7'd0);

        step(0, 1, 0, 0);
        idle(64);
        step(0, 0, 1, 0);
        idle(60);
        chk("lap_h7", HEX7, segtab[0]);
        chk("lap_h6", HEX6, segtab[3]);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("live_h7", HEX7, segtab[0]);
        chk("live_h6", HEX6, segtab[6]);

        step(0, 1, 1, 0);
        chk("prio_run", {6'b0, running}, 7'd0);
        idle(5);

        step(0, 0, 0, 1);
        idle(2);
        step(0, 1, 0, 0);
        nwrap = 0;
        wat = -1;
        for (int i = 1; i <= 2030; i++) begin
            step(0, 0, 0, 0);
            if (wrap === 1'b1) begin
                nwrap++;
                wat = i;
            end
        end
        chk_int("wrap_count", nwrap, 1);
        chk_int("wrap_cycle", wat, 2000);
        chk("wrap_cont_h6", HEX6, segtab[1]);

        step(1, 1, 1, 1);
        chk("midrst_run", {6'b0, running}, 7'd0);
        chk("midrst_h6", HEX6, 7'b1000000);

        for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
